// File: rtl/imem_dmem_boot_loader.sv
// Boot sequencer: streams words into IMEM then DMEM as 64-bit pairs, then times a core run window.
// Optional BOOT_LOADER_CHECKSUM_EN adds a rotate-XOR checksum of every accepted stream word.
module imem_dmem_boot_loader #(
    parameter int PC_W       = 9,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 8,
    parameter int RUN_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      inst_words,
    input  logic [CNT_W-1:0]      data_words,
    input  logic [RUN_W-1:0]      run_cycles,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  enable_load_ex_mem,
    output logic [PC_W-1:0]       InstExMemAddress,
    output logic [DATA_W-1:0]     InstExMemData1,
    output logic [DATA_W-1:0]     InstExMemData2,
    output logic [DM_ADDRESS-1:0] DataExMemAddress,
    output logic [DATA_W-1:0]     DataExMemData1,
    output logic [DATA_W-1:0]     DataExMemData2,
    output logic                  busy,
    output logic                  core_running,
    output logic                  done
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     checksum
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_I, S_LOAD_D, S_FLUSH, S_RUN, S_DONE} state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      inst_cnt, data_cnt, word_idx, phase_cnt;
    logic [RUN_W-1:0]      run_len, run_ctr;
    logic [PC_W-4:0]       i_pair;
    logic [DM_ADDRESS-4:0] d_pair;
    logic [DATA_W-1:0]     stash, pair_lo, pair_hi;
    logic                  accept, last_word, complete, run_done;

    always_comb begin
        next_state         = state;
        accept             = in_valid && in_ready;
        phase_cnt          = (state == S_LOAD_D) ? data_cnt : inst_cnt;
        last_word          = (word_idx == phase_cnt - CNT_W'(1));
        // An even-index word closes a pair only when it is the last one of the phase.
        complete           = accept && (word_idx[0] || last_word);
        pair_lo            = word_idx[0] ? stash : in_data;
        pair_hi            = word_idx[0] ? in_data : '0;
        run_done           = (run_len == '0) || (run_ctr == run_len - RUN_W'(1));
        enable_load_ex_mem = (state == S_LOAD_I) || (state == S_LOAD_D) || (state == S_FLUSH);
        busy               = (state != S_IDLE) && (state != S_DONE);
        core_running       = (state == S_RUN);
        done               = (state == S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (inst_words != '0)      next_state = S_LOAD_I;
                    else if (data_words != '0) next_state = S_LOAD_D;
                    else                       next_state = S_FLUSH;
                end
            end
            S_LOAD_I: if (accept && last_word) next_state = (data_cnt != '0) ? S_LOAD_D : S_FLUSH;
            S_LOAD_D: if (accept && last_word) next_state = S_FLUSH;
            S_FLUSH:  next_state = S_RUN;
            S_RUN:    if (run_done) next_state = S_DONE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            in_ready         <= 1'b0;
            inst_cnt         <= '0;
            data_cnt         <= '0;
            run_len          <= '0;
            run_ctr          <= '0;
            word_idx         <= '0;
            i_pair           <= '0;
            d_pair           <= '0;
            stash            <= '0;
            InstExMemAddress <= '0;
            InstExMemData1   <= '0;
            InstExMemData2   <= '0;
            DataExMemAddress <= '0;
            DataExMemData1   <= '0;
            DataExMemData2   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            state <= next_state;
            // Registered ready leaves a one-cycle bubble after the last word of each phase.
            in_ready <= ((next_state == S_LOAD_I) || (next_state == S_LOAD_D)) && !(accept && last_word);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        inst_cnt         <= inst_words;
                        data_cnt         <= data_words;
                        run_len          <= run_cycles;
                        run_ctr          <= '0;
                        word_idx         <= '0;
                        i_pair           <= '0;
                        d_pair           <= '0;
                        stash            <= '0;
                        InstExMemAddress <= '0;
                        InstExMemData1   <= '0;
                        InstExMemData2   <= '0;
                        DataExMemAddress <= '0;
                        DataExMemData1   <= '0;
                        DataExMemData2   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        checksum         <= '0;
`endif
                    end
                end
                S_LOAD_I, S_LOAD_D: begin
                    if (accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ in_data;
`endif
                        word_idx <= last_word ? '0 : word_idx + CNT_W'(1);
                        if (!complete) begin
                            stash <= in_data;
                        end else if (state == S_LOAD_I) begin
                            InstExMemAddress <= {i_pair, 3'b000};
                            InstExMemData1   <= pair_lo;
                            InstExMemData2   <= pair_hi;
                            i_pair           <= i_pair + 1'b1;
                        end else begin
                            DataExMemAddress <= {d_pair, 3'b000};
                            DataExMemData1   <= pair_lo;
                            DataExMemData2   <= pair_hi;
                            d_pair           <= d_pair + 1'b1;
                        end
                    end
                end
                S_RUN: if (!run_done) run_ctr <= run_ctr + RUN_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_boot_loader.sv
// Scoreboard bench for imem_dmem_boot_loader: expected pair writes are queued, a monitor checks them.
module tb_imem_dmem_boot_loader;

    localparam int PC_W = 9, DM_ADDRESS = 9, DATA_W = 32, CNT_W = 8, RUN_W = 16;
    typedef logic [PC_W+2*DATA_W-1:0] pair_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [CNT_W-1:0]      inst_words = '0, data_words = '0;
    logic [RUN_W-1:0]      run_cycles = '0;
    logic                  in_valid = 1'b0;
    logic [DATA_W-1:0]     in_data = '0;
    logic                  in_ready, enable_load_ex_mem, busy, core_running, done;
    logic [PC_W-1:0]       InstExMemAddress;
    logic [DATA_W-1:0]     InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
    logic [DM_ADDRESS-1:0] DataExMemAddress;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]     checksum;
`endif

    int n_checks = 0, n_fail = 0;
    int en_cnt = 0, run_cnt = 0;
    pair_t exp_inst[$], exp_data[$];
    pair_t prev_i = '0, prev_d = '0;

    imem_dmem_boot_loader #(
        .PC_W(PC_W), .DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .CNT_W(CNT_W), .RUN_W(RUN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .inst_words(inst_words), .data_words(data_words), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .enable_load_ex_mem(enable_load_ex_mem),
        .InstExMemAddress(InstExMemAddress), .InstExMemData1(InstExMemData1),
        .InstExMemData2(InstExMemData2),
        .DataExMemAddress(DataExMemAddress), .DataExMemData1(DataExMemData1),
        .DataExMemData2(DataExMemData2),
        .busy(busy), .core_running(core_running), .done(done)
`ifdef BOOT_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic pair_t mk(input logic [8:0] a, input logic [31:0] d1, input logic [31:0] d2);
        return {a, d1, d2};
    endfunction

    // Monitor: any change of a pair triple is a memory-write event; all-zero triples are start/reset clears.
    always @(negedge clk) begin
        pair_t gi, gd, e;
        if (enable_load_ex_mem) en_cnt++;
        if (core_running) run_cnt++;
        if (!reset) begin
            gi = {InstExMemAddress, InstExMemData1, InstExMemData2};
            gd = {DataExMemAddress, DataExMemData1, DataExMemData2};
            if (gi != prev_i) begin
                if (gi != '0) begin
                    e = (exp_inst.size() != 0) ? exp_inst.pop_front() : '1;
                    check("inst_pair", 96'(gi), 96'(e));
                end
                prev_i = gi;
            end
            if (gd != prev_d) begin
                if (gd != '0) begin
                    e = (exp_data.size() != 0) ? exp_data.pop_front() : '1;
                    check("data_pair", 96'(gd), 96'(e));
                end
                prev_d = gd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int iw, input int dw, input int rc);
        inst_words = CNT_W'(iw);
        data_words = CNT_W'(dw);
        run_cycles = RUN_W'(rc);
        en_cnt = 0;
        run_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data = w;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", 96'(in_ready), 96'(1));
        tick();
        in_valid = 1'b0;
        in_data = '0;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 96'({done, busy}), 96'(2'b10));
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_ctrl", 96'({in_ready, enable_load_ex_mem, busy, core_running, done}), 96'(0));
        check("reset_pairs", 96'({InstExMemAddress, DataExMemAddress, InstExMemData1, DataExMemData2}), 96'(0));

        // Two instruction words, no data.
        exp_inst.push_back(mk(9'd0, 32'h00500093, 32'h00A00113));
        do_start(2, 0, 10);
        send(32'h00500093, 0);
        send(32'h00A00113, 0);
        check("t1_ready_after_last", 96'(in_ready), 96'(0));
        wait_done("t1");
        check("t1_enable_cycles", 96'(en_cnt), 96'(3));
        check("t1_run_cycles", 96'(run_cnt), 96'(10));

        // Odd instruction count, zero-length run window.
        exp_inst.push_back(mk(9'd0, 32'h11111111, 32'h22222222));
        exp_inst.push_back(mk(9'd8, 32'hDEADBEEF, 32'h0));
        do_start(3, 0, 0);
        send(32'h11111111, 0);
        send(32'h22222222, 0);
        send(32'hDEADBEEF, 0);
        check("t2_ready_after_last", 96'(in_ready), 96'(0));
        wait_done("t2");
        check("t2_run_cycles", 96'(run_cnt), 96'(1));

        // Data only: instruction phase skipped.
        exp_data.push_back(mk(9'd0, 32'hA0000000, 32'hA0000001));
        exp_data.push_back(mk(9'd8, 32'hA0000002, 32'hA0000003));
        do_start(0, 4, 2);
        for (int i = 0; i < 4; i++) send(32'hA0000000 + 32'(i), 0);
        wait_done("t3");
        check("t3_enable_cycles", 96'(en_cnt), 96'(5));
        check("t3_run_cycles", 96'(run_cnt), 96'(2));
        check("t3_inst_untouched", 96'({InstExMemAddress, InstExMemData1, InstExMemData2}), 96'(0));

        // Gapped stream across both phases, odd data count.
        exp_inst.push_back(mk(9'd0, 32'hB0000000, 32'hB0000001));
        exp_inst.push_back(mk(9'd8, 32'hB0000002, 32'hB0000003));
        exp_data.push_back(mk(9'd0, 32'hC0000000, 32'hC0000001));
        exp_data.push_back(mk(9'd8, 32'hC0000002, 32'h0));
        do_start(4, 3, 1);
        for (int i = 0; i < 4; i++) send(32'hB0000000 + 32'(i), (i == 3) ? 0 : 1);
        check("t4_ready_bubble", 96'({in_ready, enable_load_ex_mem}), 96'(2'b01));
        for (int i = 0; i < 3; i++) send(32'hC0000000 + 32'(i), 1);
        wait_done("t4");

        // Start pulse during a load must be ignored.
        exp_data.push_back(mk(9'd0, 32'hD0000000, 32'hD0000001));
        exp_data.push_back(mk(9'd8, 32'hD0000002, 32'hD0000003));
        do_start(0, 4, 3);
        send(32'hD0000000, 0);
        send(32'hD0000001, 0);
        inst_words = 8'd7;
        data_words = 8'd1;
        run_cycles = 16'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_after_start", 96'({busy, enable_load_ex_mem}), 96'(2'b11));
        send(32'hD0000002, 0);
        send(32'hD0000003, 0);
        wait_done("t5");
        check("t5_run_cycles", 96'(run_cnt), 96'(3));

        // Reset mid data load.
        exp_data.push_back(mk(9'd0, 32'hE0000000, 32'hE0000001));
        do_start(0, 6, 5);
        for (int i = 0; i < 3; i++) send(32'hE0000000 + 32'(i), 0);
        reset = 1'b1;
        tick();
        check("t6_reset_ctrl", 96'({enable_load_ex_mem, busy, in_ready, core_running, done}), 96'(0));
        check("t6_reset_pairs", 96'({DataExMemAddress, DataExMemData1, DataExMemData2}), 96'(0));
        reset = 1'b0;
        tick();

        // Single word after reset: stale stash must not leak in.
        exp_inst.push_back(mk(9'd0, 32'h12345678, 32'h0));
        do_start(1, 0, 1);
        send(32'h12345678, 0);
        wait_done("t7");

`ifdef BOOT_LOADER_CHECKSUM_EN
        exp_inst.push_back(mk(9'd0, 32'h1, 32'h2));
        do_start(2, 0, 1);
        send(32'h1, 0);
        check("csum_first", 96'(checksum), 96'(1));
        send(32'h2, 0);
        wait_done("csum");
        check("csum_final", 96'(checksum), 96'(0));
`endif

        repeat (2) tick();
        check("inst_queue_drained", 96'(exp_inst.size()), 96'(0));
        check("data_queue_drained", 96'(exp_data.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
